// File: rtl/wheel_ctl_pkg.sv
// Shared types and constants for the two-wheel command controller.
package wheel_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_REV  = 2'd2,
    ST_DEAD = 2'd3
  } wheel_state_e;

  typedef struct packed {
    logic fwd;
    logic rev;
  } wheel_req_t;

  // Shortened timing used when the block is built for simulation.
  localparam int SIM_DEAD_CYCLES = 8;
  localparam int SIM_MAX_RUN     = 64;

  // Pick the simulation constant when SIMULATE is set, else the real value.
  function automatic int eff_param(input int sim, input int real_v, input int sim_v);
    return (sim != 0) ? sim_v : real_v;
  endfunction

endpackage

// File: rtl/wheel_fsm.sv
// Per-wheel IDLE/FWD/REV/DEAD controller with dead-time counter.
// Optional run watchdog enabled by macro WHEEL_CMD_CTL_WATCHDOG_EN.
module wheel_fsm
  import wheel_ctl_pkg::*;
#(
  parameter int DEAD_CYCLES = 1000000,
  parameter int MAX_RUN     = 500000000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  wheel_req_t i_req,
  output logic       o_fwd,
  output logic       o_rev,
  output logic       o_dead_nxt,
  output logic       o_wdog_trip
);

  localparam int DW = $clog2(DEAD_CYCLES + 1);

  wheel_state_e  r_state, w_state_nxt;
  logic [DW-1:0] r_dead_cnt;
  logic          r_fwd, r_rev;
  logic          w_want_fwd, w_want_rev, w_timeout, w_trip;

  // A direction is only valid when exactly one request is up and motion is enabled.
  assign w_want_fwd = i_req.fwd & ~i_req.rev & i_enable;
  assign w_want_rev = i_req.rev & ~i_req.fwd & i_enable;

`ifdef WHEEL_CMD_CTL_WATCHDOG_EN
  localparam int RW = $clog2(MAX_RUN + 1);

  logic [RW-1:0] r_run_cnt;
  logic          r_trip;
  logic          w_run;

  assign w_run     = (r_state == ST_FWD) || (r_state == ST_REV);
  assign w_timeout = w_run && (r_run_cnt == RW'(MAX_RUN - 1));
  assign w_trip    = r_trip;

  // Run-length counter (zero outside FWD/REV, so it starts clean on entry) and sticky trip flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_run_cnt <= '0;
      r_trip    <= 1'b0;
    end else begin
      r_run_cnt <= w_run ? r_run_cnt + 1'b1 : '0;
      if (w_timeout)                  r_trip <= 1'b1;
      else if (!i_req.fwd && !i_req.rev) r_trip <= 1'b0;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_trip    = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; requests are ignored while the dead time runs.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (!w_trip) begin
                 if (w_want_fwd)      w_state_nxt = ST_FWD;
                 else if (w_want_rev) w_state_nxt = ST_REV;
               end
      ST_FWD:  if (!w_want_fwd || w_timeout) w_state_nxt = ST_DEAD;
      ST_REV:  if (!w_want_rev || w_timeout) w_state_nxt = ST_DEAD;
      ST_DEAD: if (r_dead_cnt == '0) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Dead-time counter: loaded on entry to DEAD, counts down to zero.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                                         r_dead_cnt <= '0;
    else if (r_state != ST_DEAD && w_state_nxt == ST_DEAD) r_dead_cnt <= DW'(DEAD_CYCLES - 1);
    else if (r_state == ST_DEAD && r_dead_cnt != '0)     r_dead_cnt <= r_dead_cnt - 1'b1;
  end

  // Registered command outputs, decoded from the state being entered so they track the state exactly.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_fwd <= 1'b0;
      r_rev <= 1'b0;
    end else begin
      r_fwd <= (w_state_nxt == ST_FWD);
      r_rev <= (w_state_nxt == ST_REV);
    end
  end

  assign o_fwd       = r_fwd;
  assign o_rev       = r_rev;
  assign o_dead_nxt  = (w_state_nxt == ST_DEAD);
  assign o_wdog_trip = w_trip;

endmodule

// File: rtl/wheel_cmd_ctl.sv
// Two-wheel Rojobot command controller: parameter resolution, two wheel_fsm
// instances and the shared busy flag. Watchdog macro: WHEEL_CMD_CTL_WATCHDOG_EN.
module wheel_cmd_ctl
  import wheel_ctl_pkg::*;
#(
  parameter int DEAD_CYCLES = 1000000,
  parameter int MAX_RUN     = 500000000,
  parameter int SIMULATE    = 0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_left_fwd_req,
  input  logic       i_left_rev_req,
  input  logic       i_right_fwd_req,
  input  logic       i_right_rev_req,
  output logic       o_left_fwd,
  output logic       o_left_rev,
  output logic       o_right_fwd,
  output logic       o_right_rev,
  output logic       o_busy,
  output logic [1:0] o_wdog_trip
);

  localparam int NUM_WHEELS = 2;
  localparam int DEAD_EFF   = eff_param(SIMULATE, DEAD_CYCLES, SIM_DEAD_CYCLES);
  localparam int MAX_EFF    = eff_param(SIMULATE, MAX_RUN, SIM_MAX_RUN);

  // Wheel index 1 is left, 0 is right, matching the wdog_trip bit order.
  wheel_req_t [NUM_WHEELS-1:0] w_req;
  logic       [NUM_WHEELS-1:0] w_fwd, w_rev, w_dead_nxt, w_trip;
  logic                        r_busy;

  assign w_req[1] = {i_left_fwd_req, i_left_rev_req};
  assign w_req[0] = {i_right_fwd_req, i_right_rev_req};

  for (genvar g = 0; g < NUM_WHEELS; g++) begin : g_wheel
    wheel_fsm #(
      .DEAD_CYCLES (DEAD_EFF),
      .MAX_RUN     (MAX_EFF)
    ) u_fsm (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_enable    (i_enable),
      .i_req       (w_req[g]),
      .o_fwd       (w_fwd[g]),
      .o_rev       (w_rev[g]),
      .o_dead_nxt  (w_dead_nxt[g]),
      .o_wdog_trip (w_trip[g])
    );
  end

  // busy mirrors "either wheel in DEAD" with no extra lag behind the states.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_busy <= 1'b0;
    else         r_busy <= |w_dead_nxt;
  end

  assign o_left_fwd  = w_fwd[1];
  assign o_left_rev  = w_rev[1];
  assign o_right_fwd = w_fwd[0];
  assign o_right_rev = w_rev[0];
  assign o_busy      = r_busy;
  assign o_wdog_trip = w_trip;

endmodule

// File: tb/tb_wheel_cmd_ctl.sv
// Bench for wheel_cmd_ctl (SIMULATE=1): directed scenarios plus random
// requests, every cycle compared with a behavioural model.
module tb_wheel_cmd_ctl;

  localparam int D = 8;
  localparam int M = 64;
`ifdef WHEEL_CMD_CTL_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] req;   // {left_fwd, left_rev, right_fwd, right_rev}
  logic       lf, lr, rf, rr, busy;
  logic [1:0] trip;
  logic [6:0] dv;

  int n_chk = 0;
  int n_err = 0;

  // Model: direction (+1 fwd, -1 rev, 0 none), remaining dead cycles, cycles run, trip flag.
  int m_dir[2];
  int m_dead[2];
  int m_run[2];
  bit m_trip[2];

  always #5 clk = ~clk;

  wheel_cmd_ctl #(.SIMULATE(1)) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en),
    .i_left_fwd_req(req[3]), .i_left_rev_req(req[2]),
    .i_right_fwd_req(req[1]), .i_right_rev_req(req[0]),
    .o_left_fwd(lf), .o_left_rev(lr), .o_right_fwd(rf), .o_right_rev(rr),
    .o_busy(busy), .o_wdog_trip(trip)
  );

  assign dv = {lf, lr, rf, rr, busy, trip};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void mdl_reset();
    for (int w = 0; w < 2; w++) begin
      m_dir[w] = 0; m_dead[w] = 0; m_run[w] = 0; m_trip[w] = 1'b0;
    end
  endfunction

  function automatic void mdl_step(input logic [3:0] r, input logic e);
    for (int w = 0; w < 2; w++) begin
      bit f       = r[2*w+1];
      bit b       = r[2*w];
      int want    = (e && f && !b) ? 1 : ((e && b && !f) ? -1 : 0);
      bit tripped = 1'b0;
      if (m_dead[w] > 0) m_dead[w]--;
      else if (m_dir[w] != 0) begin
        if (WD && m_run[w] == M) begin
          tripped = 1'b1; m_dir[w] = 0; m_dead[w] = D;
        end else if (want != m_dir[w]) begin
          m_dir[w] = 0; m_dead[w] = D;
        end else m_run[w]++;
      end else if (want != 0 && !m_trip[w]) begin
        m_dir[w] = want; m_run[w] = 1;
      end
      if (tripped)      m_trip[w] = 1'b1;
      else if (!f && !b) m_trip[w] = 1'b0;
    end
  endfunction

  function automatic logic [6:0] mdl_vec();
    logic [6:0] v;
    v[6] = (m_dead[1] == 0) && (m_dir[1] == 1);
    v[5] = (m_dead[1] == 0) && (m_dir[1] == -1);
    v[4] = (m_dead[0] == 0) && (m_dir[0] == 1);
    v[3] = (m_dead[0] == 0) && (m_dir[0] == -1);
    v[2] = (m_dead[0] > 0) || (m_dead[1] > 0);
    v[1] = m_trip[1];
    v[0] = m_trip[0];
    return v;
  endfunction

  // Apply inputs for n cycles from a falling edge, comparing after each rising edge.
  task automatic cyc(input logic [3:0] r, input logic e, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      req = r; en = e;
      @(posedge clk);
      mdl_step(r, e);
      @(negedge clk);
      chk(tag, dv, mdl_vec());
    end
  endtask

  // Asynchronous reset from a falling edge; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    mdl_reset();
    chk(tag, dv, 7'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int gap, bcnt;
    logic [3:0] rr_req;
    logic       rr_en;
    rst = 1'b1; en = 1'b1; req = 4'b0000;
    mdl_reset();
    @(negedge clk);
    chk("reset", dv, 7'd0);
    @(negedge clk);
    rst = 1'b0;

    // Start and hold left forward.
    cyc(4'b1000, 1'b1, 6, "fwd_start");

    // Reversal: count cycles with both left outputs low, and busy cycles.
    gap = 0; bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(4'b0100, 1'b1, 1, "reverse");
      if (lr) break;
      gap++;
      if (busy) bcnt++;
    end
    chk("rev_gap", gap, D + 1);
    chk("rev_busy", bcnt, D);
    cyc(4'b0100, 1'b1, 5, "rev_hold");

    // Both right requests high: right stays off, left keeps running.
    cyc(4'b0111, 1'b1, 20, "right_both");
    chk("right_both_off", {rf, rr}, 2'b00);
    cyc(4'b0000, 1'b1, 12, "idle");

    // Both forward, enable drops for one cycle, requests held.
    cyc(4'b1010, 1'b1, 5, "both_fwd");
    gap = 0;
    cyc(4'b1010, 1'b0, 1, "en_low");
    chk("en_busy", busy, 1'b1);
    gap++;
    for (int i = 0; i < 40; i++) begin
      cyc(4'b1010, 1'b1, 1, "en_restart");
      if (lf) break;
      gap++;
    end
    chk("en_gap", gap, D + 1);
    chk("en_sync", {lf, rf}, 2'b11);
    cyc(4'b0000, 1'b1, 12, "idle");

    // Long right-forward hold.
    cyc(4'b0010, 1'b1, 100, "wdog_hold");
    chk("wdog_trip", trip, WD ? 2'b01 : 2'b00);
    chk("wdog_fwd", rf, WD ? 1'b0 : 1'b1);
    cyc(4'b0000, 1'b1, 1, "wdog_release");
    chk("wdog_clear", trip, 2'b00);
    cyc(4'b0000, 1'b1, 10, "idle");
    cyc(4'b0010, 1'b1, 3, "wdog_restart");
    chk("wdog_restart_on", rf, 1'b1);
    cyc(4'b0000, 1'b1, 12, "idle");

    // Reset three cycles into a dead period, then immediate restart.
    cyc(4'b1000, 1'b1, 5, "pre_dead");
    cyc(4'b0000, 1'b1, 4, "in_dead");
    chk("in_dead_busy", busy, 1'b1);
    do_reset("reset_dead");
    cyc(4'b1000, 1'b1, 1, "post_reset");
    chk("no_dead", lf, 1'b1);

    // Random requests with persistence so runs and dead periods both occur.
    rr_req = 4'b0000; rr_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) rr_req = 4'($urandom);
      if ($urandom_range(63) == 0) rr_en = ~rr_en;
      if ($urandom_range(599) == 0) do_reset("rand_reset");
      cyc(rr_req, rr_en, 1, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/wheel_cmd_ctl.md
WHEEL_CMD_CTL -- requirements
Module: wheel_cmd_ctl

Interface
REQ-001 Parameter DEAD_CYCLES, default 1000000, shall set the per-wheel off time before a restart (10 ms at 100 MHz); legal range 1 or more.
REQ-002 Parameter MAX_RUN, default 500000000, shall set the watchdog run limit in cycles (5 s).
REQ-003 Parameter SIMULATE, default 0; when 1, the effective DEAD_CYCLES shall be 8 and the effective MAX_RUN shall be 64.
REQ-004 clk  in  1  100 MHz system clock; the block shall use only this one clock.
REQ-005 reset  in  1  reset, asynchronous and active-high.
REQ-006 enable  in  1  global motion enable; low shall mean stop and inhibit new starts.
REQ-007 left_fwd_req, left_rev_req, right_fwd_req, right_rev_req  in  1 each  debounced button requests.
REQ-008 left_fwd, left_rev, right_fwd, right_rev  out  1 each  registered wheel commands to the Rojobot.
REQ-009 busy  out  1  high while either wheel is in DEAD.
REQ-010 wdog_trip  out  2  per-wheel watchdog flags: [1] left, [0] right.

Function
REQ-011 Each wheel shall run an independent FSM with states IDLE, FWD, REV, DEAD.
REQ-012 IDLE: fwd_req & ~rev_req & enable -> FWD; rev_req & ~fwd_req & enable -> REV; otherwise stay in IDLE, including both requests high.
REQ-013 FWD: stay while fwd_req & ~rev_req & enable; otherwise -> DEAD with the dead counter loaded to DEAD_CYCLES-1.
REQ-014 REV: symmetric to FWD with fwd and rev swapped.
REQ-015 DEAD: when the counter is 0 -> IDLE, else decrement; requests shall be ignored in DEAD.
REQ-016 fwd/rev outputs shall be the registered decode of FWD/REV: 1-cycle latency from request sampling; fwd and rev of one wheel shall never be high together.
REQ-017 Direction reversal with both requests changing on one edge shall give exactly DEAD_CYCLES+1 cycles with both outputs low.
REQ-018 enable falling shall move every FWD/REV wheel to DEAD on the same edge; an IDLE wheel shall remain IDLE.
REQ-019 The wheels shall not interact; a simultaneous left and right request shall start both on the same edge.
REQ-020 busy shall be registered, equal to OR(state==DEAD) of the two wheels.

Reset
REQ-021 On reset assertion, both FSMs shall go to IDLE, counters to 0, all outputs and wdog_trip to 0, asynchronously.
REQ-022 A reset during FWD, REV or DEAD shall abort immediately; after release the first start shall occur on the first edge with a valid request, with no dead time.

Configuration
REQ-023 With macro WHEEL_CMD_CTL_WATCHDOG_EN defined, each wheel shall count cycles spent in FWD/REV, and the count shall clear on entering either state.
REQ-024 With the macro defined, reaching MAX_RUN cycles shall force the wheel to DEAD and set its wdog_trip bit.
REQ-025 With the macro defined, a set wdog_trip bit shall block IDLE -> FWD/REV for that wheel.
REQ-026 With the macro defined, a set wdog_trip bit shall clear on the first edge on which both of that wheel's requests are sampled low.
REQ-027 Without the macro, the block shall have no run counter and wdog_trip shall be constant 0, with the port retained.

Structure
REQ-028 The shared package wheel_ctl_pkg shall hold the state encoding (IDLE=2'd0, FWD=2'd1, REV=2'd2, DEAD=2'd3) and the SIMULATE constants 8 and 64.
REQ-029 The per-wheel FSM, counters and watchdog shall be one sub-module, wheel_fsm, instantiated twice; the top level shall contain only the parameter resolution and the busy register.

Verification (SIMULATE=1)
REQ-030 Reset, then left_fwd_req high at edge 0 -> left_fwd high from cycle 1; other outputs 0; busy 0.
REQ-031 Left FWD held, then fwd_req low and rev_req high on one edge -> left_fwd low, busy high for 8 cycles, left_rev high after exactly 9 low cycles.
REQ-032 Both right requests high from IDLE -> right outputs stay 0 indefinitely; left wheel behaviour unaffected.
REQ-033 Both wheels FWD, enable low -> both enter DEAD on the same edge; enable high again with requests still held -> restart after 9 cycles.
REQ-034 Watchdog built: right_fwd_req held 100 cycles -> right_fwd drops after 64 cycles, wdog_trip[0]=1, and no restart until the request is released, after which the bit clears.
REQ-035 Reset asserted mid-DEAD, 3 cycles after entry -> outputs 0 immediately; after release, a request starts in 1 cycle with no dead time.
